pipeline_control: RTL and testbench
===================================

Name: pipeline_control

Overview:
- Consumer side of the hazard detection path: takes load-use, redirect, cache-wait and halt indications and drives the PC enable plus the per-latch enable and flush strobes of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sits between hazard detection, the branch/jump resolution logic, the cache hit lines and the four pipeline latches.
- Contains a small FSM for load-use bubbles, redirect refetch and halt, plus saturating stall and flush counters.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dREN_mem  in  1  load in MEM stage
dWEN_mem  in  1  store in MEM stage
lw_hazard  in  1  load-use hazard between ID and EX (from hazard detection)
branch_taken_ex  in  1  branch resolved taken in EX
jump_id  in  1  jump/jr/jal decoded in ID
halt_wb  in  1  halt instruction in WB
pc_en  out  1  PC load enable (loads next PC or redirect target)
ifid_en  out  1  IF/ID latch enable
ifid_flush  out  1  IF/ID synchronous clear to NOP (takes effect only with ifid_en=1)
idex_en  out  1  ID/EX latch enable
idex_flush  out  1  ID/EX synchronous clear to NOP (takes effect only with idex_en=1)
exmem_en  out  1  EX/MEM latch enable
memwb_en  out  1  MEM/WB latch enable
halted  out  1  sticky halt indication, registered
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of flush cycles

Behaviour:
Clock and reset:
- Single clock CLK. Reset nRST is asynchronous, active-low.
- During reset: state=RUN, halted=0, counters=0, all enables and flushes forced 0.

FSM states: RUN, LUSE, REDIRECT, HALT.
- Outputs are combinational from state and inputs.
- mem_busy = (dREN_mem|dWEN_mem) & !dhit.

Decode priority in RUN and LUSE, first match wins:
1. halt_wb: all enables 0, flushes 0; next=HALT.
2. mem_busy: freeze, all enables 0, flushes 0; state holds.
3. branch_taken_ex: pc_en=1, all latch enables 1, ifid_flush=1, idex_flush=1; next=RUN if ihit else REDIRECT.
4. jump_id: pc_en=1, all latch enables 1, ifid_flush=1; next=RUN if ihit else REDIRECT.
5. lw_hazard, RUN only (ignored in LUSE): pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=memwb_en=1; next=LUSE.
6. !ihit: pc_en=0, ifid_en=1, ifid_flush=1, other latch enables 1.
7. Otherwise: all enables 1, flushes 0.
- LUSE always returns to RUN unless cases 1-4 select HALT/REDIRECT; case 2 holds LUSE.

REDIRECT (waiting for the target fetch):
- lw_hazard and jump_id are ignored, because the squashed instruction is in ID.
- halt_wb, mem_busy and branch_taken_ex keep the same priority as in RUN.
- Otherwise: pc_en=ihit, ifid_en=ihit, ifid_flush=0, idex_en=1, idex_flush=1, exmem_en=memwb_en=1.
- Next state: RUN on ihit, else REDIRECT.

HALT:
- All enables and flushes 0; halted=1 from the first cycle after the halt_wb decode.
- Counters freeze. Only nRST exits HALT.

Counters:
- stall_cnt +1 on each cycle with pc_en=0 and state!=HALT, excluding the halt_wb decode cycle.
- flush_cnt +1 on each cycle with ifid_flush|idex_flush.
- Both saturate at 2^CNT_W-1 and never wrap.

Simultaneous events:
- branch_taken_ex and jump_id together: the branch wins, and ID/EX is flushed along with IF/ID.
- branch_taken_ex and lw_hazard together: the branch wins; no LUSE entry.
- Reset asserted mid-stall or in HALT: immediate return to RUN with counters cleared.

Test Plan:
1. Reset, then ihit=1 with all other inputs 0 for 5 cycles -> all enables 1, flushes 0, stall_cnt=0, flush_cnt=0, halted=0.
2. lw_hazard=1 for 2 cycles, ihit=1 -> cycle 1: pc_en=0, ifid_en=0, idex_flush=1; cycle 2 (LUSE, hazard ignored): all enables 1; stall_cnt=1, flush_cnt=1.
3. dREN_mem=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles with all enables 0, then all enables 1; stall_cnt=3, state stays RUN.
4. branch_taken_ex=1 with ihit=0, then ihit=0 for 2 cycles, then ihit=1 -> flushes on cycle 1; REDIRECT bubbles for 2 cycles with pc_en=0, idex_flush=1; pc_en=ifid_en=1 on the ihit cycle; flush_cnt=4.
5. branch_taken_ex=1, jump_id=1, lw_hazard=1 in the same cycle, ihit=1 -> ifid_flush=idex_flush=1, pc_en=1, next state RUN (no LUSE).
6. halt_wb=1 while mem_busy=1 -> all enables 0 and halted=1 next cycle; stays halted for 10 cycles despite ihit/dhit toggling; nRST pulse clears halted and counters.
7. Force stall_cnt to 2^CNT_W-1, apply one more stall -> stall_cnt holds at 2^CNT_W-1.

Source files
------------

// File: rtl/pipeline_control_if.sv
// Handshake bundle between hazard detection / cache hit lines and the
// pipeline latch enables driven by pipeline_control.
interface pipeline_control_if #(
   parameter int CNT_W = 16
);
   logic             ihit;
   logic             dhit;
   logic             dREN_mem;
   logic             dWEN_mem;
   logic             lw_hazard;
   logic             branch_taken_ex;
   logic             jump_id;
   logic             halt_wb;
   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_en;
   logic             idex_flush;
   logic             exmem_en;
   logic             memwb_en;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output ihit, dhit, dREN_mem, dWEN_mem, lw_hazard, branch_taken_ex, jump_id, halt_wb,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
      input  halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  ihit, dhit, dREN_mem, dWEN_mem, lw_hazard, branch_taken_ex, jump_id, halt_wb,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
      output halted, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_control.sv
// Pipeline stall/flush sequencer: turns hazard, redirect, cache-wait and
// halt indications into PC and pipeline-latch enables and flush strobes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow, full decode priority
// LUSE     | one bubble inserted for a load-use hazard, hazard now ignored
// REDIRECT | waiting for the fetch at a branch/jump target
// HALT     | halt retired, everything frozen until reset
module pipeline_control #(
   parameter int CNT_W = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   pipeline_control_if.slave bus
);
   typedef enum logic [1:0] {RUN, LUSE, REDIRECT, HALT} state_t;

   state_t           state, state_nxt;
   logic             mem_busy;
   logic             halt_dec;
   logic             stall_inc;
   logic             flush_inc;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   assign mem_busy = (bus.dREN_mem | bus.dWEN_mem) & ~bus.dhit;

   // state register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= RUN;
      else       state <= state_nxt;
   end

   // next-state and enable/flush decode; everything stays 0 while in reset
   always_comb begin
      state_nxt      = state;
      halt_dec       = 1'b0;
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.ifid_flush = 1'b0;
      bus.idex_en    = 1'b0;
      bus.idex_flush = 1'b0;
      bus.exmem_en   = 1'b0;
      bus.memwb_en   = 1'b0;
      if (nRST && state != HALT) begin
         if (bus.halt_wb) begin
            halt_dec  = 1'b1;
            state_nxt = HALT;
         end else if (mem_busy) begin
            state_nxt = state;
         end else if (bus.branch_taken_ex) begin
            bus.pc_en      = 1'b1;
            bus.ifid_en    = 1'b1;
            bus.ifid_flush = 1'b1;
            bus.idex_en    = 1'b1;
            bus.idex_flush = 1'b1;
            bus.exmem_en   = 1'b1;
            bus.memwb_en   = 1'b1;
            state_nxt      = bus.ihit ? RUN : REDIRECT;
         end else if (state == REDIRECT) begin
            // the instruction sitting in ID is squashed, so its jump or
            // load-use indication is meaningless here
            bus.pc_en      = bus.ihit;
            bus.ifid_en    = bus.ihit;
            bus.idex_en    = 1'b1;
            bus.idex_flush = 1'b1;
            bus.exmem_en   = 1'b1;
            bus.memwb_en   = 1'b1;
            state_nxt      = bus.ihit ? RUN : REDIRECT;
         end else if (bus.jump_id) begin
            bus.pc_en      = 1'b1;
            bus.ifid_en    = 1'b1;
            bus.ifid_flush = 1'b1;
            bus.idex_en    = 1'b1;
            bus.exmem_en   = 1'b1;
            bus.memwb_en   = 1'b1;
            state_nxt      = bus.ihit ? RUN : REDIRECT;
         end else if (bus.lw_hazard && state == RUN) begin
            bus.idex_en    = 1'b1;
            bus.idex_flush = 1'b1;
            bus.exmem_en   = 1'b1;
            bus.memwb_en   = 1'b1;
            state_nxt      = LUSE;
         end else begin
            bus.pc_en      = bus.ihit;
            bus.ifid_en    = 1'b1;
            bus.ifid_flush = ~bus.ihit;
            bus.idex_en    = 1'b1;
            bus.exmem_en   = 1'b1;
            bus.memwb_en   = 1'b1;
            state_nxt      = RUN;
         end
      end
   end

   // the halt decode cycle itself is not a stall; HALT freezes both counters
   assign stall_inc = nRST && !bus.pc_en && state != HALT && !halt_dec;
   assign flush_inc = bus.ifid_flush | bus.idex_flush;

   // sticky halt flag and saturating event counters
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         halted    <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (halt_dec) halted <= 1'b1;
         if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign bus.halted    = halted;
   assign bus.stall_cnt = stall_cnt;
   assign bus.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: directed scenarios plus random traffic, all
// checked against a reference model that classifies each cycle into an
// action and looks the strobes up from a table.
module tb_pipeline_control;
   localparam int W   = 4;
   localparam int MAX = (1 << W) - 1;

   // input vector bit positions
   localparam int IH = 7, DH = 6, DR = 5, DW = 4, LW = 3, BR = 2, JP = 1, HL = 0;

   // model modes and per-cycle actions
   localparam int M_RUN = 0, M_LUSE = 1, M_WAIT = 2, M_HALT = 3;
   localparam int A_IDLE = 0, A_BR = 1, A_JMP = 2, A_TOK = 3, A_TWAIT = 4,
                  A_LW = 5, A_MISS = 6, A_GO = 7;

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   pipeline_control_if #(.CNT_W(W)) bus();
   pipeline_control #(.CNT_W(W)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

   int checks = 0;
   int errors = 0;

   int         m_mode, m_stall, m_flush;
   bit         m_halted;
   logic [6:0] exp_vec;
   int         exp_next;
   bit         exp_stall, exp_flush, exp_halt_dec;

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
   function automatic logic [6:0] dut_vec();
      return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
              bus.idex_flush, bus.exmem_en, bus.memwb_en};
   endfunction

   function automatic logic [6:0] act_strobes(input int act);
      case (act)
         A_BR:    return 7'b1111111;
         A_JMP:   return 7'b1111011;
         A_TOK:   return 7'b1101111;
         A_TWAIT: return 7'b0001111;
         A_LW:    return 7'b0001111;
         A_MISS:  return 7'b0111011;
         A_GO:    return 7'b1101011;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic model_reset();
      m_mode   = M_RUN;
      m_stall  = 0;
      m_flush  = 0;
      m_halted = 0;
   endtask

   // apply inputs, let them settle, and work out what the model expects
   task automatic drive(input logic [7:0] v);
      bit busy;
      int act;
      bus.ihit            = v[IH];
      bus.dhit            = v[DH];
      bus.dREN_mem        = v[DR];
      bus.dWEN_mem        = v[DW];
      bus.lw_hazard       = v[LW];
      bus.branch_taken_ex = v[BR];
      bus.jump_id         = v[JP];
      bus.halt_wb         = v[HL];
      #1;
      busy         = (v[DR] | v[DW]) & ~v[DH];
      exp_halt_dec = 0;
      exp_next     = m_mode;
      act          = A_IDLE;
      if (m_mode == M_HALT) act = A_IDLE;
      else if (v[HL]) begin act = A_IDLE; exp_next = M_HALT; exp_halt_dec = 1; end
      else if (busy) act = A_IDLE;
      else if (v[BR]) begin act = A_BR; exp_next = v[IH] ? M_RUN : M_WAIT; end
      else if (v[JP] && m_mode != M_WAIT) begin act = A_JMP; exp_next = v[IH] ? M_RUN : M_WAIT; end
      else if (m_mode == M_WAIT) begin act = v[IH] ? A_TOK : A_TWAIT; exp_next = v[IH] ? M_RUN : M_WAIT; end
      else if (v[LW] && m_mode == M_RUN) begin act = A_LW; exp_next = M_LUSE; end
      else begin act = v[IH] ? A_GO : A_MISS; exp_next = M_RUN; end
      exp_vec = (nRST === 1'b1) ? act_strobes(act) : 7'b0;
      exp_stall = (nRST === 1'b1) && !exp_vec[6] && m_mode != M_HALT && !exp_halt_dec;
      exp_flush = exp_vec[4] | exp_vec[2];
   endtask

   task automatic advance();
      @(posedge CLK);
      if (nRST === 1'b1) begin
         if (exp_stall && m_stall < MAX) m_stall++;
         if (exp_flush && m_flush < MAX) m_flush++;
         if (exp_halt_dec) m_halted = 1;
         m_mode = exp_next;
      end
      @(negedge CLK);
   endtask

   task automatic apply_reset();
      nRST = 1'b0;
      model_reset();
      drive(8'h00);
      @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      model_reset();
      drive(8'hFF);
      checks++;
      if (dut_vec() !== 7'b0) begin errors++; $display("FAIL reset_strobes got %b want %b", dut_vec(), 7'b0); end
      checks++;
      if (bus.halted !== 1'b0 || bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin
         errors++; $display("FAIL reset_regs got halted=%b stall=%0d flush=%0d want 0/0/0", bus.halted, bus.stall_cnt, bus.flush_cnt);
      end
      @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic test_run();
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         drive(8'h80);
         checks++;
         if (dut_vec() !== exp_vec) begin errors++; $display("FAIL run_strobes cyc %0d got %b want %b", i, dut_vec(), exp_vec); end
         advance();
      end
      checks++;
      if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0 || bus.halted !== 1'b0) begin
         errors++; $display("FAIL run_regs got stall=%0d flush=%0d halted=%b want 0/0/0", bus.stall_cnt, bus.flush_cnt, bus.halted);
      end
   endtask

   task automatic test_load_use();
      apply_reset();
      drive(8'h88);
      checks++;
      if (dut_vec() !== 7'b0001111) begin errors++; $display("FAIL luse_bubble got %b want %b", dut_vec(), 7'b0001111); end
      advance();
      drive(8'h88);
      checks++;
      if (dut_vec() !== 7'b1101011) begin errors++; $display("FAIL luse_ignored got %b want %b", dut_vec(), 7'b1101011); end
      advance();
      checks++;
      if (bus.stall_cnt !== 4'd1 || bus.flush_cnt !== 4'd1) begin
         errors++; $display("FAIL luse_counts got stall=%0d flush=%0d want 1/1", bus.stall_cnt, bus.flush_cnt);
      end
   endtask

   task automatic test_mem_wait();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive(8'hA0);
         checks++;
         if (dut_vec() !== 7'b0) begin errors++; $display("FAIL mem_freeze cyc %0d got %b want %b", i, dut_vec(), 7'b0); end
         advance();
      end
      drive(8'hE0);
      checks++;
      if (dut_vec() !== 7'b1101011) begin errors++; $display("FAIL mem_release got %b want %b", dut_vec(), 7'b1101011); end
      advance();
      checks++;
      if (bus.stall_cnt !== 4'd3) begin errors++; $display("FAIL mem_stall_cnt got %0d want 3", bus.stall_cnt); end
   endtask

   task automatic test_redirect();
      logic [7:0] seq [4] = '{8'h04, 8'h00, 8'h00, 8'h80};
      logic [6:0] want[4] = '{7'b1111111, 7'b0001111, 7'b0001111, 7'b1101111};
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         drive(seq[i]);
         checks++;
         if (dut_vec() !== want[i]) begin errors++; $display("FAIL redirect cyc %0d got %b want %b", i, dut_vec(), want[i]); end
         advance();
      end
      checks++;
      if (bus.flush_cnt !== 4'd4 || bus.stall_cnt !== 4'd2) begin
         errors++; $display("FAIL redirect_counts got flush=%0d stall=%0d want 4/2", bus.flush_cnt, bus.stall_cnt);
      end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      drive(8'h8E);
      checks++;
      if (dut_vec() !== 7'b1111111) begin errors++; $display("FAIL simul_strobes got %b want %b", dut_vec(), 7'b1111111); end
      advance();
      // a fresh lw_hazard only bubbles if the FSM came back to RUN, not LUSE
      drive(8'h88);
      checks++;
      if (dut_vec() !== 7'b0001111) begin errors++; $display("FAIL simul_next_run got %b want %b", dut_vec(), 7'b0001111); end
      advance();
   endtask

   task automatic test_halt();
      apply_reset();
      drive(8'h80);
      advance();
      drive(8'h21);
      checks++;
      if (dut_vec() !== 7'b0) begin errors++; $display("FAIL halt_decode got %b want %b", dut_vec(), 7'b0); end
      advance();
      for (int i = 0; i < 10; i++) begin
         drive({i[0], ~i[0], 6'b0});
         checks++;
         if (dut_vec() !== 7'b0 || bus.halted !== 1'b1) begin
            errors++; $display("FAIL halt_hold cyc %0d got %b halted=%b want 0000000 halted=1", i, dut_vec(), bus.halted);
         end
         advance();
      end
      checks++;
      if (bus.stall_cnt !== 4'd0) begin errors++; $display("FAIL halt_stall_frozen got %0d want 0", bus.stall_cnt); end
      nRST = 1'b0;
      model_reset();
      #1;
      checks++;
      if (bus.halted !== 1'b0 || bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin
         errors++; $display("FAIL halt_reset got halted=%b stall=%0d flush=%0d want 0/0/0", bus.halted, bus.stall_cnt, bus.flush_cnt);
      end
      @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      drive(8'h80);
      checks++;
      if (dut_vec() !== 7'b1101011) begin errors++; $display("FAIL halt_exit got %b want %b", dut_vec(), 7'b1101011); end
      advance();
   endtask

   task automatic test_saturation();
      apply_reset();
      for (int i = 0; i < MAX + 4; i++) begin
         drive(8'h00);
         advance();
      end
      checks++;
      if (bus.stall_cnt !== 4'(MAX)) begin errors++; $display("FAIL stall_sat got %0d want %0d", bus.stall_cnt, MAX); end
      checks++;
      if (bus.flush_cnt !== 4'(MAX)) begin errors++; $display("FAIL flush_sat got %0d want %0d", bus.flush_cnt, MAX); end
      drive(8'h20);
      advance();
      checks++;
      if (bus.stall_cnt !== 4'(MAX)) begin errors++; $display("FAIL stall_sat_hold got %0d want %0d", bus.stall_cnt, MAX); end
   endtask

   task automatic test_random();
      logic [7:0] v;
      int halt_cycles = 0;
      apply_reset();
      for (int i = 0; i < 800; i++) begin
         if (m_halted && halt_cycles > 4) begin
            nRST = 1'b0;
            model_reset();
            drive(8'h00);
            checks++;
            if (dut_vec() !== 7'b0 || bus.halted !== 1'b0 || bus.stall_cnt !== '0) begin
               errors++; $display("FAIL rand_reset cyc %0d got %b halted=%b stall=%0d", i, dut_vec(), bus.halted, bus.stall_cnt);
            end
            advance();
            nRST = 1'b1;
            halt_cycles = 0;
         end
         v[IH] = ($urandom_range(99) < 75);
         v[DH] = ($urandom_range(99) < 60);
         v[DR] = ($urandom_range(99) < 20);
         v[DW] = ($urandom_range(99) < 10);
         v[LW] = ($urandom_range(99) < 25);
         v[BR] = ($urandom_range(99) < 12);
         v[JP] = ($urandom_range(99) < 12);
         v[HL] = ($urandom_range(99) < 2);
         drive(v);
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++; $display("FAIL rand_strobes cyc %0d in %b mode %0d got %b want %b", i, v, m_mode, dut_vec(), exp_vec);
         end
         checks++;
         if (bus.halted !== m_halted || bus.stall_cnt !== 4'(m_stall) || bus.flush_cnt !== 4'(m_flush)) begin
            errors++; $display("FAIL rand_regs cyc %0d got halted=%b stall=%0d flush=%0d want %b/%0d/%0d",
                               i, bus.halted, bus.stall_cnt, bus.flush_cnt, m_halted, m_stall, m_flush);
         end
         advance();
         if (m_halted) halt_cycles++;
      end
   endtask

   initial begin
      nRST = 1'b0;
      model_reset();
      drive(8'h00);
      @(negedge CLK);
      test_reset();
      test_run();
      test_load_use();
      test_mem_wait();
      test_redirect();
      test_simultaneous();
      test_halt();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
